// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encoding and HMS limits for the timer blocks
package timer_pkg;

    localparam int SEC_W = 7;
    localparam int HR_W  = 5;

    localparam logic [SEC_W-1:0] MAX_SEC = 7'd59;
    localparam logic [SEC_W-1:0] MAX_MIN = 7'd59;
    localparam logic [HR_W-1:0]  MAX_HR  = 5'd23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides clk down to a one-cycle tick every CLK_HZ enabled cycles
module tick_prescaler #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;
    logic             at_last;

    assign at_last = (cnt == LAST);
    assign tick    = en && !clr && at_last;

    // The count holds while en is low so a paused timer resumes mid-second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - HH:MM:SS down-counter with load/start/stop and expiry pulse
module countdown_timer
    import timer_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [HR_W-1:0]  load_hr,
    input  logic [SEC_W-1:0] load_min,
    input  logic [SEC_W-1:0] load_sec,
    input  logic             start,
    input  logic             stop,
    output logic [HR_W-1:0]  cur_hr,
    output logic [SEC_W-1:0] cur_min,
    output logic [SEC_W-1:0] cur_sec,
    output logic             running,
    output logic             expired,
    output logic             done
);

    timer_state_t     state, state_nx;
    logic [HR_W-1:0]  hr_nx;
    logic [SEC_W-1:0] min_nx, sec_nx;
    logic             expired_nx;
    logic             tick;
    logic             nonzero;

    assign nonzero = (cur_hr != '0) || (cur_min != '0) || (cur_sec != '0);

    tick_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == RUN),
        .clr   (load),
        .tick  (tick)
    );

    always_comb begin
        state_nx   = state;
        hr_nx      = cur_hr;
        min_nx     = cur_min;
        sec_nx     = cur_sec;
        expired_nx = 1'b0;

        if (load) begin
            state_nx = IDLE;
            hr_nx    = (load_hr  > MAX_HR)  ? MAX_HR  : load_hr;
            min_nx   = (load_min > MAX_MIN) ? MAX_MIN : load_min;
            sec_nx   = (load_sec > MAX_SEC) ? MAX_SEC : load_sec;
        end else begin
            case (state)
                IDLE: begin
                    if (!stop && start && nonzero) state_nx = RUN;
                end
                RUN: begin
                    if (stop) begin
                        state_nx = PAUSE;
                    end else if (tick) begin
                        if (cur_sec != '0) begin
                            sec_nx = cur_sec - 1'b1;
                        end else if (cur_min != '0) begin
                            sec_nx = MAX_SEC;
                            min_nx = cur_min - 1'b1;
                        end else begin
                            sec_nx = MAX_SEC;
                            min_nx = MAX_MIN;
                            hr_nx  = cur_hr - 1'b1;
                        end
                        // RUN is only entered with a nonzero time, so the only way to
                        // reach zero here is from 00:00:01.
                        if (cur_hr == '0 && cur_min == '0 && cur_sec == 7'd1) begin
                            state_nx   = DONE;
                            expired_nx = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (!stop && start) state_nx = RUN;
                end
                DONE: begin
                    state_nx = DONE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_hr  <= '0;
            cur_min <= '0;
            cur_sec <= '0;
            running <= 1'b0;
            expired <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            cur_hr  <= hr_nx;
            cur_min <= min_nx;
            cur_sec <= sec_nx;
            running <= (state_nx == RUN);
            expired <= expired_nx;
            done    <= (state_nx == DONE);
        end
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Hours/minutes/seconds down-counter for the alarm clock, counting from a loaded HH:MM:SS value to 00:00:00 at 1 Hz.
- Provides the decrement counterpart to the second-increment datapath.
- Drives the seven-segment display mux with cur_hr/cur_min/cur_sec.
- Raises an expiry pulse to the alarm/buzzer logic.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency; one tick every CLK_HZ cycles (benches use 4).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle strobe; captures load_hr/load_min/load_sec.
- load_hr  in  5  hours to load, 0..23.
- load_min  in  7  minutes to load, 0..59.
- load_sec  in  7  seconds to load, 0..59.
- start  in  1  one-cycle strobe; begin or resume counting.
- stop  in  1  one-cycle strobe; pause counting.
- cur_hr  out  5  current hours.
- cur_min  out  7  current minutes.
- cur_sec  out  7  current seconds.
- running  out  1  high while in RUN.
- expired  out  1  one-cycle pulse when the count reaches 00:00:00 from RUN.
- done  out  1  level, high while in DONE.

Behaviour:
- Reset (rst_n=0, asynchronous): cur_hr=0, cur_min=0, cur_sec=0, state=IDLE, prescaler=0, running=0, expired=0, done=0. All outputs are registered.
- States and transitions:
  - IDLE: start with a nonzero time -> RUN; start with 00:00:00 is ignored.
  - RUN: stop -> PAUSE; tick -> decrement.
  - PAUSE: start -> RUN; prescaler value is retained, not cleared.
  - DONE: start and stop are ignored; only load exits.
- Load:
  - Accepted in every state; next state is IDLE and the prescaler clears to 0.
  - Clamping: load_sec>59 -> 59, load_min>59 -> 59, load_hr>23 -> 23.
- Priority within one cycle: load > stop > start.
- Prescaler:
  - Counts 0..CLK_HZ-1, but only in RUN.
  - tick is asserted in RUN when the prescaler equals CLK_HZ-1; the prescaler then wraps to 0.
  - The first decrement after start from IDLE occurs CLK_HZ cycles later.
- Decrement on tick:
  - sec>0: sec-1.
  - sec==0, min>0: sec=59, min-1.
  - sec==0, min==0, hr>0: sec=59, min=59, hr-1.
- Expiry:
  - When a decrement produces 00:00:00, the same clock edge enters DONE, sets done=1 and sets expired=1.
  - expired clears on the next cycle.
  - The counter holds 00:00:00 in DONE; no underflow.
- A stop in the same cycle as a tick wins: no decrement occurs and the state becomes PAUSE.
- Reset asserted mid-count returns immediately to reset values; counting does not resume after deassertion without load and start.
- running = (state==RUN). done = (state==DONE).

Decomposition:
- Shared package (timer_pkg):
  - State enum IDLE/RUN/PAUSE/DONE (2-bit).
  - Constants MAX_SEC=59, MAX_MIN=59, MAX_HR=23.
  - Width constants SEC_W=7, HR_W=5.
- One sub-module: tick_prescaler.
  - Parameter CLK_HZ; inputs clk, rst_n, en, clr; output tick.
  - Reused by the clock and alarm blocks.
- HMS decrement logic stays inline in countdown_timer.

Test Plan (CLK_HZ=4):
- Reset during RUN at 00:00:05 -> all outputs 0 within the same cycle; after release, start is ignored because the time is 00:00:00.
- Load 00:00:03, start -> cur_sec 2,1,0 at 4-cycle intervals; expired high exactly one cycle at the 12th cycle after start; done stays high; further start strobes ignored.
- Load 01:00:00, start, 1 tick -> 00:59:59; load 00:01:00, 1 tick -> 00:00:59.
- Load 00:00:10, start, stop after 6 cycles -> cur_sec=9 and holds for 20 cycles with running=0; start -> cur_sec=8 after 2 more cycles (prescaler retained).
- Load hr=31, min=75, sec=60 -> 23:59:59 in IDLE.
- Same-cycle strobes:
  - load and start together -> IDLE with the loaded time.
  - start and stop together in IDLE -> remains IDLE.
  - stop coincident with tick -> PAUSE, no decrement.
